// File: rtl/loader_pkg.sv
// Shared types and defaults for the boot-time program loader.
package loader_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned TMR_W  = 24;

  localparam logic [WORD_W-1:0] END_MARKER_DEF = 32'hFFFF_FFFF;
  localparam logic [TMR_W-1:0]  TIMEOUT_DEF    = 24'd1000000;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

endpackage

// File: rtl/program_loader.sv
// Boot sequencer: packs received bytes into 32-bit words, writes them to program
// memory until the end marker arrives, then releases the CPU and forwards bytes.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned         ADDR_W     = 14,
  parameter logic [WORD_W-1:0]   END_MARKER = END_MARKER_DEF,
  parameter logic [TMR_W-1:0]    TIMEOUT    = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              xrst,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_changed,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_run,
  output logic [ADDR_W:0]   word_count,
  output logic              overflow,
  output logic [BYTE_W-1:0] fwd_data,
  output logic              fwd_valid
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(TIMEOUT - 24'd1);

  state_e              state_q;
  logic [1:0]          byte_cnt_q;
  logic [WORD_W-1:0]   shift_q;
  logic [TMR_W-1:0]    timer_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [WORD_W-1:0]   mem_wdata_q;
  logic                cpu_run_q;
  logic [CNT_W-1:0]    word_count_q;
  logic                overflow_q;
  logic [BYTE_W-1:0]   fwd_data_q;
  logic                fwd_valid_q;

  logic [WORD_W-1:0]   word_d;
  logic                mem_full_c;

  assign word_d     = {shift_q[WORD_W-BYTE_W-1:0], rx_data};
  // Count never exceeds 2**ADDR_W, so its MSB alone flags a full memory.
  assign mem_full_c = word_count_q[ADDR_W];

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q      <= ST_LOAD;
      byte_cnt_q   <= 2'd0;
      shift_q      <= '0;
      timer_q      <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_run_q    <= 1'b0;
      word_count_q <= '0;
      overflow_q   <= 1'b0;
      fwd_data_q   <= '0;
      fwd_valid_q  <= 1'b0;
    end else begin
      mem_we_q     <= 1'b0;
      fwd_valid_q  <= 1'b0;
      // Counter follows the write pulse by one cycle.
      word_count_q <= word_count_q + CNT_W'(mem_we_q);
      unique case (state_q)
        ST_LOAD: begin
          if (rx_changed) begin
            shift_q    <= word_d;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            timer_q    <= '0;
            if (byte_cnt_q == 2'd3) begin
              if (word_d == END_MARKER) begin
                cpu_run_q <= 1'b1;
                state_q   <= ST_RUN;
              end else if (mem_full_c) begin
                overflow_q <= 1'b1;
                state_q    <= ST_ERR;
              end else begin
                mem_we_q    <= 1'b1;
                mem_addr_q  <= word_count_q[ADDR_W-1:0];
                mem_wdata_q <= word_d;
              end
            end
          end else if (byte_cnt_q != 2'd0) begin
            // Idle too long mid-word: drop the partial word.
            if (timer_q == TIMER_LAST) begin
              byte_cnt_q <= 2'd0;
              timer_q    <= '0;
            end else begin
              timer_q <= timer_q + 24'd1;
            end
          end
        end
        ST_RUN: begin
          if (rx_changed) begin
            fwd_data_q  <= rx_data;
            fwd_valid_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_run    = cpu_run_q;
  assign word_count = word_count_q;
  assign overflow   = overflow_q;
  assign fwd_data   = fwd_data_q;
  assign fwd_valid  = fwd_valid_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a full-size instance and a 4-word instance.
module tb_program_loader;

  localparam logic [23:0] TMO = 24'd16;

  logic        clk;
  logic        xrst, xrst2;
  logic [7:0]  rx_data, rx2_data;
  logic        rx_changed, rx2_changed;

  logic        mem_we, mem_we2;
  logic [13:0] mem_addr;
  logic [1:0]  mem_addr2;
  logic [31:0] mem_wdata, mem_wdata2;
  logic        cpu_run, cpu_run2;
  logic [14:0] word_count;
  logic [2:0]  word_count2;
  logic        overflow, overflow2;
  logic [7:0]  fwd_data, fwd_data2;
  logic        fwd_valid, fwd_valid2;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int wr_cnt2 = 0;

  program_loader #(.ADDR_W(14), .END_MARKER(32'hFFFF_FFFF), .TIMEOUT(TMO)) dut (
    .clk(clk), .xrst(xrst), .rx_data(rx_data), .rx_changed(rx_changed),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_run(cpu_run), .word_count(word_count), .overflow(overflow),
    .fwd_data(fwd_data), .fwd_valid(fwd_valid)
  );

  program_loader #(.ADDR_W(2), .END_MARKER(32'hFFFF_FFFF), .TIMEOUT(TMO)) dut2 (
    .clk(clk), .xrst(xrst2), .rx_data(rx2_data), .rx_changed(rx2_changed),
    .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .cpu_run(cpu_run2), .word_count(word_count2), .overflow(overflow2),
    .fwd_data(fwd_data2), .fwd_valid(fwd_valid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-pulse counters, sampled on the rising edge before outputs update.
  always @(posedge clk) begin
    if (mem_we)  wr_cnt  <= wr_cnt + 1;
    if (mem_we2) wr_cnt2 <= wr_cnt2 + 1;
  end

  typedef struct {
    logic [31:0] word;
    logic        exp_we;
    logic [13:0] exp_addr;
    logic [31:0] exp_data;
    logic        exp_run;
    logic [14:0] exp_cnt;
  } vec_t;

  vec_t vecs [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; strobes one byte and returns at the next negedge
  // (cycle t+1 after the capturing edge t), so consecutive calls are back-to-back.
  task automatic send_byte(input bit sel, input logic [7:0] b);
    if (sel) begin rx2_data = b; rx2_changed = 1'b1; end
    else     begin rx_data  = b; rx_changed  = 1'b1; end
    @(negedge clk);
    if (sel) rx2_changed = 1'b0;
    else     rx_changed  = 1'b0;
  endtask

  task automatic send_word(input bit sel, input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(sel, w[8*i +: 8]);
  endtask

  task automatic do_reset(input bit sel);
    if (sel) xrst2 = 1'b0; else xrst = 1'b0;
    idle(2);
    if (sel) xrst2 = 1'b1; else xrst = 1'b1;
    idle(1);
  endtask

  initial begin
    int w0;
    logic [7:0] b;
    xrst = 1'b0; xrst2 = 1'b0;
    rx_data = '0; rx_changed = 1'b0;
    rx2_data = '0; rx2_changed = 1'b0;
    vecs[0] = '{32'h0000_0001, 1'b1, 14'd0, 32'h0000_0001, 1'b0, 15'd1};
    vecs[1] = '{32'h1234_5678, 1'b1, 14'd1, 32'h1234_5678, 1'b0, 15'd2};
    vecs[2] = '{32'hFFFF_FFFF, 1'b0, 14'd1, 32'h1234_5678, 1'b1, 15'd2};

    idle(3);
    chk("rst_mem_we",     32'(mem_we), 32'd0);
    chk("rst_mem_addr",   32'(mem_addr), 32'd0);
    chk("rst_mem_wdata",  mem_wdata, 32'd0);
    chk("rst_cpu_run",    32'(cpu_run), 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    chk("rst_overflow",   32'(overflow), 32'd0);
    chk("rst_fwd",        32'({fwd_valid, fwd_data}), 32'd0);
    xrst = 1'b1; xrst2 = 1'b1;
    idle(1);

    // Two words then end marker
    foreach (vecs[i]) begin
      send_word(1'b0, vecs[i].word);
      chk($sformatf("t1_we[%0d]", i),   32'(mem_we),   32'(vecs[i].exp_we));
      chk($sformatf("t1_addr[%0d]", i), 32'(mem_addr), 32'(vecs[i].exp_addr));
      chk($sformatf("t1_data[%0d]", i), mem_wdata,     vecs[i].exp_data);
      chk($sformatf("t1_run[%0d]", i),  32'(cpu_run),  32'(vecs[i].exp_run));
      idle(1);
      chk($sformatf("t1_cnt[%0d]", i),  32'(word_count), 32'(vecs[i].exp_cnt));
      chk($sformatf("t1_we_off[%0d]", i), 32'(mem_we), 32'd0);
    end
    chk("t1_wr_total", 32'(wr_cnt), 32'd2);

    // Forwarding after load, back-to-back strobes
    w0 = wr_cnt;
    for (int i = 1; i <= 4; i++) begin
      b = 8'(i);
      send_byte(1'b0, b);
      chk($sformatf("t2_fwd_valid[%0d]", i), 32'(fwd_valid), 32'd1);
      chk($sformatf("t2_fwd_data[%0d]", i),  32'(fwd_data),  32'(b));
    end
    idle(1);
    chk("t2_fwd_valid_off", 32'(fwd_valid), 32'd0);
    chk("t2_fwd_data_hold", 32'(fwd_data), 32'h04);
    idle(2);
    chk("t2_no_write", 32'(wr_cnt - w0), 32'd0);
    chk("t2_run_hold", 32'(cpu_run), 32'd1);

    // Empty program
    do_reset(1'b0);
    w0 = wr_cnt;
    send_word(1'b0, 32'hFFFF_FFFF);
    chk("t3_we",  32'(mem_we), 32'd0);
    chk("t3_run", 32'(cpu_run), 32'd1);
    idle(1);
    chk("t3_cnt", 32'(word_count), 32'd0);
    chk("t3_no_write", 32'(wr_cnt - w0), 32'd0);

    // Gap of TIMEOUT-1 idle cycles keeps the partial word
    do_reset(1'b0);
    send_byte(1'b0, 8'hAA); send_byte(1'b0, 8'hBB);
    idle(int'(TMO) - 1);
    send_byte(1'b0, 8'hCC); send_byte(1'b0, 8'hDD);
    chk("t4a_we",   32'(mem_we), 32'd1);
    chk("t4a_data", mem_wdata, 32'hAABB_CCDD);

    // Gap of TIMEOUT idle cycles discards it
    do_reset(1'b0);
    send_byte(1'b0, 8'hAA); send_byte(1'b0, 8'hBB);
    idle(int'(TMO));
    send_word(1'b0, 32'hDEAD_BEEF);
    chk("t4b_we",   32'(mem_we), 32'd1);
    chk("t4b_addr", 32'(mem_addr), 32'd0);
    chk("t4b_data", mem_wdata, 32'hDEAD_BEEF);
    send_word(1'b0, 32'hFFFF_FFFF);
    chk("t4b_run", 32'(cpu_run), 32'd1);
    idle(1);
    chk("t4b_cnt", 32'(word_count), 32'd1);

    // Overflow on the 4-word instance
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) begin
      send_word(1'b1, 32'hA000_0000 | 32'(i));
      chk($sformatf("t5_we[%0d]", i),   32'(mem_we2),   32'd1);
      chk($sformatf("t5_addr[%0d]", i), 32'(mem_addr2), 32'(i));
      chk($sformatf("t5_data[%0d]", i), mem_wdata2,     32'hA000_0000 | 32'(i));
    end
    send_word(1'b1, 32'hA000_0004);
    chk("t5_ovf_we",  32'(mem_we2), 32'd0);
    chk("t5_ovf",     32'(overflow2), 32'd1);
    chk("t5_ovf_run", 32'(cpu_run2), 32'd0);
    chk("t5_ovf_cnt", 32'(word_count2), 32'd4);
    send_word(1'b1, 32'hFFFF_FFFF);
    idle(2);
    chk("t5_marker_ignored", 32'(cpu_run2), 32'd0);
    chk("t5_ovf_sticky", 32'(overflow2), 32'd1);
    chk("t5_wr_total", 32'(wr_cnt2), 32'd4);
    chk("t5_addr_hold", 32'(mem_addr2), 32'd3);
    chk("t5_data_hold", mem_wdata2, 32'hA000_0003);
    chk("t5_fwd_none", 32'(fwd_valid2), 32'd0);

    // Reset in the middle of the second word
    do_reset(1'b0);
    send_word(1'b0, 32'h0102_0304);
    idle(1);
    chk("t6_pre_cnt", 32'(word_count), 32'd1);
    send_byte(1'b0, 8'h55); send_byte(1'b0, 8'h66);
    xrst = 1'b0;
    #1;
    chk("t6_async_cnt",  32'(word_count), 32'd0);
    chk("t6_async_addr", 32'(mem_addr), 32'd0);
    chk("t6_async_data", mem_wdata, 32'd0);
    idle(1);
    xrst = 1'b1;
    idle(1);
    send_word(1'b0, 32'h1122_3344);
    chk("t6_we",   32'(mem_we), 32'd1);
    chk("t6_addr", 32'(mem_addr), 32'd0);
    chk("t6_data", mem_wdata, 32'h1122_3344);
    idle(1);
    chk("t6_cnt", 32'(word_count), 32'd1);

    // Last byte of one word and first byte of the next on consecutive cycles
    do_reset(1'b0);
    send_word(1'b0, 32'hCAFE_F00D);
    chk("t7_we0",   32'(mem_we), 32'd1);
    chk("t7_addr0", 32'(mem_addr), 32'd0);
    chk("t7_data0", mem_wdata, 32'hCAFE_F00D);
    send_word(1'b0, 32'h0BAD_BEEF);
    chk("t7_we1",   32'(mem_we), 32'd1);
    chk("t7_addr1", 32'(mem_addr), 32'd1);
    chk("t7_data1", mem_wdata, 32'h0BAD_BEEF);
    idle(1);
    chk("t7_cnt", 32'(word_count), 32'd2);
    chk("t7_run", 32'(cpu_run), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
